// File: rtl/imem_port_arb.sv
// Instruction-memory port arbiter: external loader vs. core fetch on one single-port imem.
// Define IMEM_ARB_RR_EN to alternate contended LOAD cycles between loader and fetch.
module imem_port_arb #(
  parameter int LEN_W  = 16,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [LEN_W-1:0]  load_len,
  output logic              load_busy,
  output logic              load_done,
  input  logic              exIns_valid,
  input  logic [31:0]       exIns_in,
  output logic              exIns_ren,
  output logic [ADDR_W-1:0] exIns_addr,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_rvalid,
  output logic [31:0]       fetch_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  state_t            r_state, w_next;
  logic [LEN_W-1:0]  r_count, r_len;
  logic [ADDR_W-1:0] r_addr;
  logic              r_rvalid;
  logic              w_ld_own, w_acc, w_last;

`ifdef IMEM_ARB_RR_EN
  logic r_fetch_turn;
  logic w_contend;
  assign w_contend = fetch_req && exIns_valid;
  // Contended cycles alternate starting with the loader; otherwise whoever asks owns the port.
  assign w_ld_own  = w_contend ? !r_fetch_turn : !fetch_req;

  always_ff @(posedge clk) begin
    if (rst || r_state != S_LOAD) r_fetch_turn <= 1'b0;
    else if (w_contend)           r_fetch_turn <= !r_fetch_turn;
  end
`else
  assign w_ld_own = 1'b1;
`endif

  // The reset cycle must not commit a word, so acceptance is gated by rst.
  assign w_acc  = exIns_ren && exIns_valid;
  assign w_last = (r_count == r_len - LEN_W'(1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (load_start) w_next = (load_len == '0) ? S_DONE : S_LOAD;
      S_LOAD: if (w_acc && w_last) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    load_busy = (r_state == S_LOAD);
    load_done = (r_state == S_DONE);
    exIns_ren = (r_state == S_LOAD) && w_ld_own && !rst;
    fetch_gnt = fetch_req && ((r_state != S_LOAD) || !w_ld_own);
    mem_en    = w_acc || fetch_gnt;
    mem_we    = w_acc;
    mem_addr  = w_acc ? r_addr : fetch_addr;
    mem_wdata = w_acc ? exIns_in : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count  <= '0;
      r_len    <= '0;
      r_addr   <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= fetch_gnt;
      if (r_state == S_IDLE && load_start) begin
        r_count <= '0;
        r_len   <= load_len;
        r_addr  <= load_base;
      end else if (w_acc) begin
        r_count <= r_count + LEN_W'(1);
        r_addr  <= r_addr + ADDR_W'(4);
      end
    end
  end

  assign exIns_addr   = r_addr;
  assign fetch_rvalid = r_rvalid;
  assign fetch_rdata  = mem_rdata;

endmodule

// File: tb/tb_imem_port_arb.sv
// Directed bench for imem_port_arb: write and fetch-data scoreboards plus per-cycle checks.
module tb_imem_port_arb;
  localparam int AW = 32;
  localparam int LW = 16;
  localparam logic [31:0] K = 32'h5A5A_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_start;
  logic [AW-1:0] load_base;
  logic [LW-1:0] load_len;
  logic          load_busy, load_done;
  logic          exIns_valid;
  logic [31:0]   exIns_in;
  logic          exIns_ren;
  logic [AW-1:0] exIns_addr;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_gnt, fetch_rvalid;
  logic [31:0]   fetch_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] wq[$];
  logic [31:0] fq[$];

  imem_port_arb #(.LEN_W(LW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .load_start(load_start), .load_base(load_base), .load_len(load_len),
    .load_busy(load_busy), .load_done(load_done),
    .exIns_valid(exIns_valid), .exIns_in(exIns_in),
    .exIns_ren(exIns_ren), .exIns_addr(exIns_addr),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_gnt(fetch_gnt), .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: read data is a known function of the read address.
  always @(posedge clk)
    mem_rdata <= (mem_en && !mem_we) ? (mem_addr ^ K) : 32'hDEAD_BEEF;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Write and fetch-data scoreboards.
  always @(negedge clk) begin
    if (mem_we) begin
      n_cmp++;
      assert (wq.size() != 0) else begin
        n_err++;
        $error("FAIL unexp_write: got %0h/%0h want none", mem_addr, mem_wdata);
      end
      if (wq.size() != 0) chk("write", {mem_addr, mem_wdata}, wq.pop_front());
      chk("write_en", {63'd0, mem_en}, 64'd1);
    end
    if (fetch_rvalid) begin
      n_cmp++;
      assert (fq.size() != 0) else begin
        n_err++;
        $error("FAIL unexp_rvalid: got %0h want none", fetch_rdata);
      end
      if (fq.size() != 0) chk("rdata", {32'd0, fetch_rdata}, {32'd0, fq.pop_front()});
    end
  end

  initial begin
    rst = 1'b1; load_start = 1'b0; load_base = '0; load_len = '0;
    exIns_valid = 1'b0; exIns_in = '0; fetch_req = 1'b0; fetch_addr = '0;
    step(); step();
    @(negedge clk);
    chk("rst_busy",  {63'd0, load_busy}, 64'd0);
    chk("rst_done",  {63'd0, load_done}, 64'd0);
    chk("rst_rv",    {63'd0, fetch_rvalid}, 64'd0);
    chk("rst_ren",   {63'd0, exIns_ren}, 64'd0);
    chk("rst_exadr", {32'd0, exIns_addr}, 64'd0);
    step(); rst = 1'b0;

    // Three-word load with constant valid
    step(); load_start = 1'b1; load_base = 32'h100; load_len = 16'd3;
    @(negedge clk); chk("a_busy0", {63'd0, load_busy}, 64'd0);
    step(); load_start = 1'b0; load_base = '0; exIns_valid = 1'b1; exIns_in = 32'hA000_0000;
    wq.push_back({32'h100, 32'hA000_0000});
    @(negedge clk);
    chk("a_busy1", {63'd0, load_busy}, 64'd1);
    chk("a_ren1",  {63'd0, exIns_ren}, 64'd1);
    chk("a_adr0",  {32'd0, exIns_addr}, 64'h100);
    step(); exIns_in = 32'hA000_0001; wq.push_back({32'h104, 32'hA000_0001});
    @(negedge clk); chk("a_adr1", {32'd0, exIns_addr}, 64'h104);
    step(); exIns_in = 32'hA000_0002; wq.push_back({32'h108, 32'hA000_0002});
    @(negedge clk); chk("a_done_early", {63'd0, load_done}, 64'd0);
    step(); exIns_valid = 1'b0;
    @(negedge clk);
    chk("a_done", {63'd0, load_done}, 64'd1);
    chk("a_busy_done", {63'd0, load_busy}, 64'd0);
    chk("a_ren_done", {63'd0, exIns_ren}, 64'd0);
    chk("a_wq_empty", 64'(wq.size()), 64'd0);
    step(); @(negedge clk); chk("a_done_pulse", {63'd0, load_done}, 64'd0);

    // Zero-length load
    step(); load_start = 1'b1; load_base = 32'h700; load_len = 16'd0;
    @(negedge clk); chk("b_done0", {63'd0, load_done}, 64'd0);
    step(); load_start = 1'b0;
    @(negedge clk);
    chk("b_done1", {63'd0, load_done}, 64'd1);
    chk("b_busy1", {63'd0, load_busy}, 64'd0);
    chk("b_we",    {63'd0, mem_we}, 64'd0);
    step(); @(negedge clk);
    chk("b_done2", {63'd0, load_done}, 64'd0);
    chk("b_busy2", {63'd0, load_busy}, 64'd0);

    // Gapped valid 1,0,1,1, with a stray load_start mid-load
    step(); load_start = 1'b1; load_base = 32'h200; load_len = 16'd3;
    step(); load_start = 1'b0; exIns_valid = 1'b1; exIns_in = 32'hB000_0000;
    wq.push_back({32'h200, 32'hB000_0000});
    step(); exIns_valid = 1'b0; load_start = 1'b1; load_base = 32'h999; load_len = 16'd5;
    @(negedge clk);
    chk("c_ren_gap", {63'd0, exIns_ren}, 64'd1);
    chk("c_we_gap",  {63'd0, mem_we}, 64'd0);
    chk("c_adr_gap", {32'd0, exIns_addr}, 64'h204);
    step(); load_start = 1'b0; exIns_valid = 1'b1; exIns_in = 32'hB000_0001;
    wq.push_back({32'h204, 32'hB000_0001});
    step(); exIns_in = 32'hB000_0002; wq.push_back({32'h208, 32'hB000_0002});
    @(negedge clk); chk("c_done_early", {63'd0, load_done}, 64'd0);
    step(); exIns_valid = 1'b0;
    @(negedge clk);
    chk("c_done", {63'd0, load_done}, 64'd1);
    chk("c_wq_empty", 64'(wq.size()), 64'd0);
    step(); exIns_valid = 1'b1; exIns_in = 32'hBAD0_0000;
    @(negedge clk);
    chk("c_idle_ren", {63'd0, exIns_ren}, 64'd0);
    chk("c_idle_we",  {63'd0, mem_we}, 64'd0);
    step(); exIns_valid = 1'b0;

    // Reset mid-load, then a fresh load at a new base
    step(); load_start = 1'b1; load_base = 32'h300; load_len = 16'd4;
    step(); load_start = 1'b0; exIns_valid = 1'b1; exIns_in = 32'hD000_0000;
    wq.push_back({32'h300, 32'hD000_0000});
    step(); exIns_in = 32'hD000_0001; wq.push_back({32'h304, 32'hD000_0001});
    step(); rst = 1'b1; exIns_in = 32'hD000_0002;
    @(negedge clk); chk("d_rst_we", {63'd0, mem_we}, 64'd0);
    step(); rst = 1'b0;
    @(negedge clk);
    chk("d_ren",   {63'd0, exIns_ren}, 64'd0);
    chk("d_busy",  {63'd0, load_busy}, 64'd0);
    chk("d_done",  {63'd0, load_done}, 64'd0);
    chk("d_exadr", {32'd0, exIns_addr}, 64'd0);
    step(); exIns_valid = 1'b0; load_start = 1'b1; load_base = 32'h400; load_len = 16'd1;
    step(); load_start = 1'b0; exIns_valid = 1'b1; exIns_in = 32'hE000_0000;
    wq.push_back({32'h400, 32'hE000_0000});
    @(negedge clk); chk("d_new_adr", {32'd0, exIns_addr}, 64'h400);
    step(); exIns_valid = 1'b0;
    @(negedge clk);
    chk("d_new_done", {63'd0, load_done}, 64'd1);
    chk("d_wq_empty", 64'(wq.size()), 64'd0);

    // Fetch held across a two-word load
    step(); fetch_req = 1'b1; fetch_addr = 32'h40; fq.push_back(32'h40 ^ K);
    @(negedge clk); chk("e_idle_gnt", {63'd0, fetch_gnt}, 64'd1);
    step(); fetch_addr = 32'h44; fq.push_back(32'h44 ^ K);
    load_start = 1'b1; load_base = 32'h500; load_len = 16'd2;
    @(negedge clk); chk("e_idle_gnt2", {63'd0, fetch_gnt}, 64'd1);
    step(); load_start = 1'b0; fetch_addr = 32'h48;
    exIns_valid = 1'b1; exIns_in = 32'hF000_0000; wq.push_back({32'h500, 32'hF000_0000});
    @(negedge clk);
    chk("e_c1_gnt", {63'd0, fetch_gnt}, 64'd0);
    chk("e_c1_ren", {63'd0, exIns_ren}, 64'd1);
`ifdef IMEM_ARB_RR_EN
    step(); fetch_addr = 32'h4C; exIns_in = 32'hF000_0001; fq.push_back(32'h4C ^ K);
    @(negedge clk);
    chk("e_c2_gnt", {63'd0, fetch_gnt}, 64'd1);
    chk("e_c2_ren", {63'd0, exIns_ren}, 64'd0);
    step(); fetch_addr = 32'h50; wq.push_back({32'h504, 32'hF000_0001});
    @(negedge clk);
    chk("e_c3_gnt", {63'd0, fetch_gnt}, 64'd0);
    chk("e_c3_ren", {63'd0, exIns_ren}, 64'd1);
    step(); exIns_valid = 1'b0; fetch_addr = 32'h54; fq.push_back(32'h54 ^ K);
`else
    step(); fetch_addr = 32'h4C; exIns_in = 32'hF000_0001;
    wq.push_back({32'h504, 32'hF000_0001});
    @(negedge clk);
    chk("e_c2_gnt", {63'd0, fetch_gnt}, 64'd0);
    chk("e_c2_ren", {63'd0, exIns_ren}, 64'd1);
    step(); exIns_valid = 1'b0; fetch_addr = 32'h54; fq.push_back(32'h54 ^ K);
`endif
    @(negedge clk);
    chk("e_done", {63'd0, load_done}, 64'd1);
    chk("e_done_gnt", {63'd0, fetch_gnt}, 64'd1);
    step(); fetch_req = 1'b0;
    step(); step();
    chk("e_wq_empty", 64'(wq.size()), 64'd0);
    chk("e_fq_empty", 64'(fq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/imem_port_arb.md
IMEM_PORT_ARB -- requirements
Module: imem_port_arb

Interface
REQ-001 Parameter LEN_W, default 16, width of the load word-count field and internal load counter.
REQ-002 Parameter ADDR_W, default 32, width of all byte addresses.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 load_start  input  1  one-cycle request to begin an external instruction load.
REQ-006 load_base  input  ADDR_W  byte address of the first loaded word, sampled with load_start.
REQ-007 load_len  input  LEN_W  number of 32-bit words to load, sampled with load_start.
REQ-008 load_busy  output  1  high while in LOAD.
REQ-009 load_done  output  1  one-cycle pulse when a load completes.
REQ-010 exIns_valid  input  1  external word available.
REQ-011 exIns_in  input  32  external instruction word.
REQ-012 exIns_ren  output  1  block accepts exIns_in this cycle.
REQ-013 exIns_addr  output  ADDR_W  destination byte address of the current external word.
REQ-014 fetch_req  input  1  core fetch request.
REQ-015 fetch_addr  input  ADDR_W  core fetch byte address.
REQ-016 fetch_gnt  output  1  fetch granted the memory port this cycle.
REQ-017 fetch_rvalid  output  1  fetch_rdata valid; one cycle after fetch_gnt.
REQ-018 fetch_rdata  output  32  fetched instruction.
REQ-019 mem_en, mem_we  output  1 each  single-port imem enable and write enable.
REQ-020 mem_addr  output  ADDR_W; mem_wdata output 32; mem_rdata input 32 (1-cycle read latency).

Function
REQ-021 States: IDLE, LOAD, DONE; transitions IDLE->LOAD on load_start with load_len!=0, IDLE->DONE on load_start with load_len==0, LOAD->DONE on acceptance of word load_len-1, DONE->IDLE unconditionally.
REQ-022 In IDLE and DONE, fetch_gnt = fetch_req; mem_en=1, mem_we=0, mem_addr=fetch_addr when granted.
REQ-023 In LOAD, exIns_ren shall be high whenever the loader owns the port; a word is accepted when exIns_valid && exIns_ren.
REQ-024 On acceptance: mem_en=1, mem_we=1, mem_addr=exIns_addr, mem_wdata=exIns_in in the same cycle; counter increments, exIns_addr advances by 4 next cycle.
REQ-025 exIns_addr shall equal load_base + 4*count, registered; load_base captured on load_start.
REQ-026 fetch_rvalid shall be a registered copy of fetch_gnt; fetch_rdata = mem_rdata.
REQ-027 load_busy = (state==LOAD); load_done high only in DONE.
REQ-028 load_start while in LOAD or DONE shall be ignored.
REQ-029 exIns_valid outside LOAD shall be ignored; exIns_ren low outside LOAD.
REQ-030 Address arithmetic wraps modulo 2^ADDR_W; counter compares against load_len-1 with no overflow beyond LEN_W.

Reset
REQ-031 rst forces state IDLE, counter 0, exIns_addr 0, fetch_rvalid 0, load_done 0, load_busy 0.
REQ-032 rst during LOAD aborts the load with no load_done pulse; the word presented in the reset cycle is not written.

Configuration
REQ-033 Macro IMEM_ARB_RR_EN.
REQ-034 Without IMEM_ARB_RR_EN: in LOAD the loader has strict priority; fetch_gnt is held 0 for the entire load.
REQ-035 With IMEM_ARB_RR_EN: in LOAD, when fetch_req and exIns_valid are both high, ownership alternates each cycle starting with the loader; an uncontended requester is always granted.

Verification
REQ-036 Load load_base=0x100, load_len=3, exIns_valid constant -> writes to 0x100,0x104,0x108 in 3 consecutive cycles, load_done pulse on the 4th cycle.
REQ-037 load_len=0 -> no mem_we, load_done one cycle after load_start, back to IDLE.
REQ-038 exIns_valid toggling 1,0,1,1 with load_len=3 -> exactly 3 writes, addresses contiguous, done after last accepted word.
REQ-039 rst asserted after 2 of 4 words -> state IDLE, no load_done, exIns_ren 0 next cycle; new load restarts at its own base.
REQ-040 fetch_req held during load: without macro fetch_gnt=0 throughout; with IMEM_ARB_RR_EN fetch_gnt alternates with exIns_ren, fetch_rvalid follows one cycle later with mem_rdata.
